cma_host_ctrl: RTL and testbench
================================

Name: cma_host_ctrl

Overview:
- Host-side sequencer that stands in for the board FPGA in front of the cma array.
- Loads a block of words into cma memory through the external port, then raises RUN and waits for DONE.
- After DONE, reads back a result block through the same port and folds it into a checksum.
- Sits at top level beside cma; every handshake wire to cma is driven or sampled here.

Parameters:
DATA_W, 32, external data bus width
EXA_W, 16, external address width
ROMULTIC_W, 8, ROMULTIC (memory-target select) bits width
START_DLY, 4, idle cycles after reset release before LOAD
LOAD_WORDS, 16, words written in LOAD (0 allowed)
LOAD_BASE, 0, first LOAD address
LOAD_ROMUL, 1, ROMULTIC value driven during LOAD
READ_WORDS, 8, words read back (0 allowed)
READ_BASE, 256, first READ address
READ_ROMUL, 2, ROMULTIC value driven during READ

Ports:
CLK  in  1  clock; all state on rising edge
RST  in  1  asynchronous, active-high reset
RUN  out  1  start/run level to cma
BANK_SEL  out  1  1 = external port owns cma memory bank
RE_FROM_EXTERNAL  out  1  read strobe
WE_FROM_EXTERNAL  out  1  write strobe
ROMULTIC_BITS_FROM_EXTERNAL  out  ROMULTIC_W  memory target select
GLB_ADR_FROM_EXTERNAL  out  EXA_W  word address
DATA_FROM_EXTERNAL  out  DATA_W  write data
DATA_TO_EXTERNAL  in  DATA_W  read data from cma
DONE  in  1  completion flag from cma
FIN  out  1  sequence complete, sticky
CHECKSUM  out  DATA_W  XOR of all words read back

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0.
  - State IDLE; counters cleared.
  - Asserting RST mid-sequence aborts immediately; the sequence restarts from IDLE after release.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - Count START_DLY cycles, then go to LOAD.
  - If LOAD_WORDS=0, go straight to GAP1.
- LOAD: for i = 0..LOAD_WORDS-1, one word per cycle, drive:
  - WE=1, BANK_SEL=1;
  - ROMULTIC = LOAD_ROMUL;
  - ADR = LOAD_BASE + i, truncated to EXA_W (address wraps);
  - DATA = i zero-extended to DATA_W.
  - Then go to GAP1.
- GAP1: one cycle, all strobes 0, BANK_SEL=0, address and data 0. Then go to RUN.
- RUN state:
  - RUN=1, BANK_SEL=0.
  - DONE is sampled from the second RUN cycle onward. DONE in the first RUN cycle, or while RUN=0 in any other state, is ignored.
  - On the first sampled DONE=1, RUN drops on the next edge and the state goes to GAP2.
  - DONE may be a pulse or a level; only its first high sample counts.
  - No timeout; RUN is held indefinitely.
- GAP2: one cycle idle, as GAP1. Then go to READ, or to FIN if READ_WORDS=0.
- READ: for j = 0..READ_WORDS-1, one word per cycle, drive:
  - RE=1, BANK_SEL=1;
  - ROMULTIC = READ_ROMUL;
  - ADR = READ_BASE + j, wrapping.
- Read capture:
  - cma returns read data one cycle after the RE/address cycle.
  - The cycle after each RE cycle, CHECKSUM ^= DATA_TO_EXTERNAL.
  - The capture for the last word happens in the first FIN cycle.
- FIN:
  - FIN=1 and all strobes 0 in every cycle, including the first.
  - CHECKSUM is final one cycle after entering FIN.
  - Stays in FIN until reset.
- RE and WE are never high in the same cycle; WE and RUN are never high in the same cycle.

Decomposition:
- Shared package holds:
  - DATA_W, EXA_W, ROMULTIC_W (mirrors of the SMA.h values);
  - state enum IDLE, LOAD, GAP1, RUN, GAP2, READ, FIN.
- One sub-module, cma_host_xfer: address/word counter with base offset and a terminal-count flag, instantiated for both LOAD and READ.
- FSM and checksum stay in the top.

Test Plan:
- Reset then release, default params:
  - outputs 0 during reset;
  - first WE exactly START_DLY=4 cycles after release;
  - 16 WE cycles with ADR 0..15, DATA 0..15, ROMULTIC=1, BANK_SEL=1.
- Model DONE pulse 10 cycles after RUN rises:
  - RUN high exactly 11 cycles;
  - one idle GAP2 cycle;
  - 8 RE cycles with ADR 256..263, ROMULTIC=2.
- Read model returns words 0x1,0x2,0x4,...,0x80 one cycle after RE:
  - CHECKSUM = 0x000000FF;
  - FIN=1 and stays high for 100 cycles.
- DONE held high from reset and during LOAD:
  - no early exit;
  - RUN still lasts at least 2 cycles;
  - exits on the first DONE sampled from the second RUN cycle onward.
- Assert RST during the 5th LOAD cycle:
  - all outputs 0 immediately (asynchronous);
  - after release, LOAD restarts at ADR 0.
- LOAD_WORDS=0, READ_WORDS=0, LOAD_BASE=0xFFFE variant:
  - skips directly to RUN and then to FIN with CHECKSUM=0;
  - separate run with LOAD_BASE=0xFFFE, LOAD_WORDS=4 shows address wrap 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/cma_host_ctrl_pkg.sv
// Shared widths and sequencer state encoding for the cma host controller.
// Widths mirror the SMA.h values used by the cma array.
package cma_host_ctrl_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned EXA_W      = 16;
   localparam int unsigned ROMULTIC_W = 8;

   // ST_ prefix keeps state names clear of the RUN/FIN port names
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_GAP1,
      ST_RUN,
      ST_GAP2,
      ST_READ,
      ST_FIN
   } state_t;

endpackage

// File: rtl/cma_host_xfer.sv
// Word counter for one burst: exposes the word index, the based and wrapped
// address of the next word, and a terminal flag once WORDS words have gone out.
module cma_host_xfer #(
   parameter int unsigned EXA_W = cma_host_ctrl_pkg::EXA_W,
   parameter int unsigned WORDS = 1,
   parameter int unsigned BASE  = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_step,
   output logic [EXA_W-1:0] o_adr,
   output logic [31:0]      o_idx,
   output logic             o_tc
);

   logic [31:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_step) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_idx = r_cnt;
   // truncation gives the required address wrap at the top of the space
   assign o_adr = EXA_W'(BASE + r_cnt);
   assign o_tc  = (r_cnt == WORDS);

endmodule

// File: rtl/cma_host_ctrl.sv
// Host-side sequencer for cma: load a block, pulse RUN until DONE, read back
// a result block and fold it into an XOR checksum. All outputs are registered.
module cma_host_ctrl #(
   parameter int unsigned DATA_W     = cma_host_ctrl_pkg::DATA_W,
   parameter int unsigned EXA_W      = cma_host_ctrl_pkg::EXA_W,
   parameter int unsigned ROMULTIC_W = cma_host_ctrl_pkg::ROMULTIC_W,
   parameter int unsigned START_DLY  = 4,
   parameter int unsigned LOAD_WORDS = 16,
   parameter int unsigned LOAD_BASE  = 0,
   parameter int unsigned LOAD_ROMUL = 1,
   parameter int unsigned READ_WORDS = 8,
   parameter int unsigned READ_BASE  = 256,
   parameter int unsigned READ_ROMUL = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   output logic                  RUN,
   output logic                  BANK_SEL,
   output logic                  RE_FROM_EXTERNAL,
   output logic                  WE_FROM_EXTERNAL,
   output logic [ROMULTIC_W-1:0] ROMULTIC_BITS_FROM_EXTERNAL,
   output logic [EXA_W-1:0]      GLB_ADR_FROM_EXTERNAL,
   output logic [DATA_W-1:0]     DATA_FROM_EXTERNAL,
   input  logic [DATA_W-1:0]     DATA_TO_EXTERNAL,
   input  logic                  DONE,
   output logic                  FIN,
   output logic [DATA_W-1:0]     CHECKSUM
);

   import cma_host_ctrl_pkg::*;

   state_t                r_state;
   logic [31:0]           r_dly;
   logic                  r_run_armed;
   logic                  r_cap;
   logic [DATA_W-1:0]     r_chk;
   logic                  r_run;
   logic                  r_bank;
   logic                  r_re;
   logic                  r_we;
   logic [ROMULTIC_W-1:0] r_rom;
   logic [EXA_W-1:0]      r_adr;
   logic [DATA_W-1:0]     r_data;
   logic                  r_fin;

   logic                  w_dly_done;
   logic                  w_ld_issue;
   logic                  w_rd_issue;
   logic [EXA_W-1:0]      w_ld_adr;
   logic [EXA_W-1:0]      w_rd_adr;
   logic [31:0]           w_ld_idx;
   logic [31:0]           w_rd_idx;
   logic                  w_ld_tc;
   logic                  w_rd_tc;

   cma_host_xfer #(
      .EXA_W (EXA_W),
      .WORDS (LOAD_WORDS),
      .BASE  (LOAD_BASE)
   ) u_load (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_step (w_ld_issue),
      .o_adr  (w_ld_adr),
      .o_idx  (w_ld_idx),
      .o_tc   (w_ld_tc)
   );

   cma_host_xfer #(
      .EXA_W (EXA_W),
      .WORDS (READ_WORDS),
      .BASE  (READ_BASE)
   ) u_read (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_step (w_rd_issue),
      .o_adr  (w_rd_adr),
      .o_idx  (w_rd_idx),
      .o_tc   (w_rd_tc)
   );

   // A word is issued on the edge that also leaves IDLE/GAP2, so the strobe
   // register is already valid in the first LOAD/READ cycle.
   always_comb begin
      w_dly_done = 1'b0;
      w_ld_issue = 1'b0;
      w_rd_issue = 1'b0;
      w_dly_done = ((r_dly + 32'd1) >= START_DLY);
      w_ld_issue = (((r_state == ST_IDLE) && w_dly_done) || (r_state == ST_LOAD)) && !w_ld_tc;
      w_rd_issue = ((r_state == ST_GAP2) || (r_state == ST_READ)) && !w_rd_tc;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_dly       <= '0;
         r_run_armed <= 1'b0;
         r_cap       <= 1'b0;
         r_chk       <= '0;
         r_run       <= 1'b0;
         r_bank      <= 1'b0;
         r_re        <= 1'b0;
         r_we        <= 1'b0;
         r_rom       <= '0;
         r_adr       <= '0;
         r_data      <= '0;
         r_fin       <= 1'b0;
      end else begin
         // read data arrives one cycle after RE, so capture one cycle later still
         r_cap <= r_re;
         if (r_cap) begin
            r_chk <= r_chk ^ DATA_TO_EXTERNAL;
         end

         r_bank <= 1'b0;
         r_re   <= 1'b0;
         r_we   <= 1'b0;
         r_rom  <= '0;
         r_adr  <= '0;
         r_data <= '0;

         if (w_ld_issue) begin
            r_we   <= 1'b1;
            r_bank <= 1'b1;
            r_rom  <= ROMULTIC_W'(LOAD_ROMUL);
            r_adr  <= w_ld_adr;
            r_data <= DATA_W'(w_ld_idx);
         end

         if (w_rd_issue) begin
            r_re   <= 1'b1;
            r_bank <= 1'b1;
            r_rom  <= ROMULTIC_W'(READ_ROMUL);
            r_adr  <= w_rd_adr;
         end

         case (r_state)
            ST_IDLE: begin
               if (!w_dly_done) begin
                  r_dly <= r_dly + 32'd1;
               end else if (w_ld_tc) begin
                  r_state <= ST_GAP1;
               end else begin
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_ld_tc) begin
                  r_state <= ST_GAP1;
               end
            end
            ST_GAP1: begin
               r_state     <= ST_RUN;
               r_run       <= 1'b1;
               r_run_armed <= 1'b0;
            end
            ST_RUN: begin
               // first RUN cycle only arms; DONE is honoured from the second on
               if (!r_run_armed) begin
                  r_run_armed <= 1'b1;
               end else if (DONE) begin
                  r_run   <= 1'b0;
                  r_state <= ST_GAP2;
               end
            end
            ST_GAP2: begin
               if (w_rd_tc) begin
                  r_state <= ST_FIN;
                  r_fin   <= 1'b1;
               end else begin
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               if (w_rd_tc) begin
                  r_state <= ST_FIN;
                  r_fin   <= 1'b1;
               end
            end
            ST_FIN: begin
               r_fin <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign RUN                         = r_run;
   assign BANK_SEL                    = r_bank;
   assign RE_FROM_EXTERNAL            = r_re;
   assign WE_FROM_EXTERNAL            = r_we;
   assign ROMULTIC_BITS_FROM_EXTERNAL = r_rom;
   assign GLB_ADR_FROM_EXTERNAL       = r_adr;
   assign DATA_FROM_EXTERNAL          = r_data;
   assign FIN                         = r_fin;
   assign CHECKSUM                    = r_chk;

endmodule

// File: tb/tb_cma_host_ctrl.sv
// Bench for cma_host_ctrl: three parameterisations run side by side against a
// cycle-indexed phase model driven by scripted and random DONE schedules.
module tb_cma_host_ctrl;

   localparam int NI   = 3;
   localparam int MAXC = 256;
   localparam int unsigned P_SD [NI] = '{4, 4, 2};
   localparam int unsigned P_LW [NI] = '{16, 0, 4};
   localparam int unsigned P_LB [NI] = '{0, 32'hFFFE, 32'hFFFE};
   localparam int unsigned P_RW [NI] = '{8, 0, 3};
   localparam int unsigned P_RB [NI] = '{256, 256, 32'hFFFF};
   localparam int unsigned P_LR = 1;
   localparam int unsigned P_RR = 2;

   logic        CLK  = 1'b0;
   logic        RST  = 1'b1;
   logic        DONE = 1'b0;
   logic        run_o  [NI];
   logic        bank_o [NI];
   logic        re_o   [NI];
   logic        we_o   [NI];
   logic        fin_o  [NI];
   logic [7:0]  rom_o  [NI];
   logic [15:0] adr_o  [NI];
   logic [31:0] dout_o [NI];
   logic [31:0] chk_o  [NI];
   logic [31:0] din    [NI];

   int          n_checks = 0;
   int          n_errors = 0;
   bit          done_sched [MAXC];
   logic [31:0] mem [8];
   int          run_end [NI];
   logic        prev_re [NI];
   logic [15:0] prev_adr [NI];

   always #5 CLK = ~CLK;

   cma_host_ctrl u0 (
      .CLK(CLK), .RST(RST), .RUN(run_o[0]), .BANK_SEL(bank_o[0]),
      .RE_FROM_EXTERNAL(re_o[0]), .WE_FROM_EXTERNAL(we_o[0]),
      .ROMULTIC_BITS_FROM_EXTERNAL(rom_o[0]), .GLB_ADR_FROM_EXTERNAL(adr_o[0]),
      .DATA_FROM_EXTERNAL(dout_o[0]), .DATA_TO_EXTERNAL(din[0]), .DONE(DONE),
      .FIN(fin_o[0]), .CHECKSUM(chk_o[0])
   );

   cma_host_ctrl #(
      .LOAD_WORDS(0), .READ_WORDS(0), .LOAD_BASE(32'hFFFE)
   ) u1 (
      .CLK(CLK), .RST(RST), .RUN(run_o[1]), .BANK_SEL(bank_o[1]),
      .RE_FROM_EXTERNAL(re_o[1]), .WE_FROM_EXTERNAL(we_o[1]),
      .ROMULTIC_BITS_FROM_EXTERNAL(rom_o[1]), .GLB_ADR_FROM_EXTERNAL(adr_o[1]),
      .DATA_FROM_EXTERNAL(dout_o[1]), .DATA_TO_EXTERNAL(din[1]), .DONE(DONE),
      .FIN(fin_o[1]), .CHECKSUM(chk_o[1])
   );

   cma_host_ctrl #(
      .START_DLY(2), .LOAD_WORDS(4), .LOAD_BASE(32'hFFFE),
      .READ_WORDS(3), .READ_BASE(32'hFFFF)
   ) u2 (
      .CLK(CLK), .RST(RST), .RUN(run_o[2]), .BANK_SEL(bank_o[2]),
      .RE_FROM_EXTERNAL(re_o[2]), .WE_FROM_EXTERNAL(we_o[2]),
      .ROMULTIC_BITS_FROM_EXTERNAL(rom_o[2]), .GLB_ADR_FROM_EXTERNAL(adr_o[2]),
      .DATA_FROM_EXTERNAL(dout_o[2]), .DATA_TO_EXTERNAL(din[2]), .DONE(DONE),
      .FIN(fin_o[2]), .CHECKSUM(chk_o[2])
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] obs_vec(input int k);
      return 128'({run_o[k], bank_o[k], re_o[k], we_o[k], rom_o[k], adr_o[k],
                   dout_o[k], fin_o[k], chk_o[k]});
   endfunction

   // Expected outputs in cycle n after reset release, from the phase layout:
   // START_DLY idle, LOAD words, 1 gap, RUN until DONE, 1 gap, READ words, FIN.
   function automatic logic [127:0] exp_vec(input int k, input int n);
      int          sd  = int'(P_SD[k]);
      int          lw  = int'(P_LW[k]);
      int          rw  = int'(P_RW[k]);
      int          r0  = sd + lw + 1;
      int          rd0 = run_end[k] + 2;
      logic        run = 1'b0, bank = 1'b0, re = 1'b0, we = 1'b0, fin = 1'b0;
      logic [7:0]  rom = '0;
      logic [15:0] adr = '0;
      logic [31:0] dat = '0;
      logic [31:0] chk = '0;
      if (n >= sd && n < sd + lw) begin
         we = 1'b1; bank = 1'b1; rom = 8'(P_LR);
         adr = 16'(P_LB[k] + 32'(n - sd));
         dat = 32'(n - sd);
      end
      if (n >= r0 && n <= run_end[k]) run = 1'b1;
      if (n >= rd0 && n < rd0 + rw) begin
         re = 1'b1; bank = 1'b1; rom = 8'(P_RR);
         adr = 16'(P_RB[k] + 32'(n - rd0));
      end
      if (n >= rd0 + rw) fin = 1'b1;
      for (int j = 0; j < rw; j++)
         if (rd0 + j + 2 <= n) chk = chk ^ mem[j];
      return 128'({run, bank, re, we, rom, adr, dat, fin, chk});
   endfunction

   task automatic run_scn(input int mode, input int nc, input int abort_at);
      for (int c = 0; c < MAXC; c++) begin
         case (mode)
            0:       done_sched[c] = (c == 31);
            1:       done_sched[c] = 1'b1;
            2:       done_sched[c] = (c == 21 || c == 26);
            default: done_sched[c] = ($urandom_range(0, 11) == 0);
         endcase
      end
      for (int j = 0; j < 8; j++) mem[j] = (mode == 0) ? (32'd1 << j) : $urandom;
      for (int k = 0; k < NI; k++) begin
         run_end[k] = 1 << 30;
         for (int c = int'(P_SD[k] + P_LW[k]) + 2; c < MAXC; c++) begin
            if (done_sched[c]) begin
               run_end[k] = c;
               break;
            end
         end
      end

      RST  = 1'b1;
      DONE = done_sched[0];
      repeat (3) begin
         @(posedge CLK); #1;
         for (int k = 0; k < NI; k++) check($sformatf("rst_u%0d", k), obs_vec(k), '0);
      end
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 0; k < NI; k++) prev_re[k] = 1'b0;

      for (int n = 1; n <= nc; n++) begin
         @(posedge CLK); #1;
         for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d_m%0d_c%0d", k, mode, n), obs_vec(k), exp_vec(k, n));
            din[k]      = prev_re[k] ? mem[3'(prev_adr[k] - 16'(P_RB[k]))] : $urandom;
            prev_re[k]  = re_o[k];
            prev_adr[k] = adr_o[k];
         end
         if (n == abort_at) begin
            #2 RST = 1'b1;
            #1;
            for (int k = 0; k < NI; k++) check($sformatf("abort_u%0d", k), obs_vec(k), '0);
            return;
         end
         @(negedge CLK);
         DONE = done_sched[n];
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         din[k]      = '0;
         prev_re[k]  = 1'b0;
         prev_adr[k] = '0;
      end
      run_scn(0, 150, 0);
      run_scn(1, 100, 0);
      run_scn(2, 100, 0);
      run_scn(0, 20, 8);
      run_scn(0, 60, 0);
      for (int r = 0; r < 6; r++) run_scn(3, 120, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
